// File: rtl/gonso_wb_pkg.sv
// Shared definitions for the Wishbone initiator: FSM state encoding,
// register address map constants and the default bus timeout.
package gonso_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] WB_REG_ADR0 = 32'h3003_0004;
    localparam logic [31:0] WB_REG_ADR1 = 32'h3003_0008;
    localparam logic [31:0] WB_REG_ADR2 = 32'h3003_000C;

    localparam int WB_TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts cycles while enabled; expired is high during the LIMIT-th enabled
// cycle so the owner can abort on that same clock edge.
module wb_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count_q, count_d;

    // Next count: clear dominates, saturate at LAST while enabled
    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && count_q != LAST)
            count_d = count_q + 16'd1;
    end

    assign expired = enable && !clear && (count_q == LAST);

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: takes a command, runs one
// bus cycle, returns a response. Optional bus timeout enabled by defining
// WB_INITIATOR_TIMEOUT_EN; without it the initiator waits forever for ack.
module wb_initiator
    import gonso_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUS  = ST_BUS;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        timeout_hit;
    logic        bus_end;

    // Bus cycle finishes on ack (ack wins) or on timeout
    assign bus_end = (state_q == S_BUS) && (wbm_ack_i || timeout_hit);

    // FSM and datapath next-state; we/sel/dat are zeroed whenever cyc drops
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                end
            end
            S_BUS: begin
                if (bus_end) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    dat_d       = '0;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = (wbm_ack_i && !we_q) ? wbm_dat_i : 32'h0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;

    wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state_q == S_BUS),
        .clear   (state_q != S_BUS),
        .expired (timeout_hit)
    );

    // Error flag is set only by a timeout abort
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (bus_end) rsp_err_d = !wbm_ack_i;
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_err_q <= 1'b0;
        else        rsp_err_q <= rsp_err_d;
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator. The timeout scenario is compiled in when
// WB_INITIATOR_TIMEOUT_EN is defined; otherwise an indefinite-wait scenario runs.
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;

    int checks = 0;
    int failures = 0;

    // responder: acks when stb has been high for ack_after cycles (0 = never)
    int   ack_after = 0;
    int   stb_cnt = 0;
    int   cyc_cnt = 0;
    logic resp_ack = 1'b0;
    logic stray_ack = 1'b0;
    assign wbm_ack_i = resp_ack | stray_ack;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    always @(negedge clk) begin
        if (wbm_cyc_o) cyc_cnt = cyc_cnt + 1;
        if (wbm_stb_o) begin
            stb_cnt  = stb_cnt + 1;
            resp_ack = (ack_after != 0) && (stb_cnt == ack_after);
        end else begin
            stb_cnt  = 0;
            resp_ack = 1'b0;
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cyc_cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err} !== 5'b0 ||
            wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0 || rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got cyc=%b stb=%b adr=%h dat=%h sel=%h rv=%b rd=%h want all zero",
                     wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_valid, rsp_dat);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        bit ok;
        ack_after = 2;
        issue(1'b1, 32'h3003_0004, 32'h000A_BCDE, 4'hF);
        checks++;
        if (wbm_cyc_o !== 1 || wbm_stb_o !== 1 || wbm_we_o !== 1 || wbm_adr_o !== 32'h3003_0004 ||
            wbm_dat_o !== 32'h000A_BCDE || wbm_sel_o !== 4'hF || cmd_ready !== 0) begin
            failures++;
            $display("FAIL write_bus got cyc=%b we=%b adr=%h dat=%h sel=%h rdy=%b want 1 1 30030004 000abcde f 0",
                     wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || cyc_cnt != 2 || rsp_err !== 0 || rsp_dat !== 32'h0) begin
            failures++;
            $display("FAIL write_rsp got ok=%0d cyc_cycles=%0d err=%b dat=%h want 1 2 0 0", ok, cyc_cnt, rsp_err, rsp_dat);
        end
        checks++;
        if (wbm_cyc_o !== 0 || wbm_we_o !== 0 || wbm_sel_o !== 0 || wbm_dat_o !== 0 || wbm_adr_o !== 32'h3003_0004) begin
            failures++;
            $display("FAIL write_idle_bus got cyc=%b we=%b sel=%h dat=%h adr=%h want 0 0 0 0 30030004",
                     wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_adr_o);
        end
        handshake();
        checks++;
        if (rsp_valid !== 0 || cmd_ready !== 1) begin
            failures++; $display("FAIL write_handshake got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        bit ok;
        ack_after = 4;
        wbm_dat_i = 32'h1234_5678;
        issue(1'b0, 32'h3003_0008, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (wbm_cyc_o !== 1 || wbm_we_o !== 0 || wbm_adr_o !== 32'h3003_0008) begin
            failures++; $display("FAIL read_bus got cyc=%b we=%b adr=%h want 1 0 30030008", wbm_cyc_o, wbm_we_o, wbm_adr_o);
        end
        wait_rsp(ok);
        wbm_dat_i = 32'hDEAD_BEEF;
        checks++;
        if (!ok || cyc_cnt != 4 || rsp_dat !== 32'h1234_5678 || rsp_err !== 0) begin
            failures++;
            $display("FAIL read_rsp got ok=%0d cyc_cycles=%0d dat=%h err=%b want 1 4 12345678 0", ok, cyc_cnt, rsp_dat, rsp_err);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok;
        ack_after = 2;
        wbm_dat_i = 32'h0BAD_F00D;
        issue(1'b0, 32'h3003_000C, 32'h0, 4'h3);
        wait_rsp(ok);
        wbm_dat_i = 32'h0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3003_0004; cmd_dat = 32'h55; cmd_sel = 4'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (!ok || rsp_valid !== 1 || rsp_dat !== 32'h0BAD_F00D || cmd_ready !== 0 || wbm_cyc_o !== 0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d] got rv=%b dat=%h rdy=%b cyc=%b want 1 0badf00d 0 0",
                         i, rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 0 || cmd_ready !== 1 || wbm_cyc_o !== 0) begin
            failures++; $display("FAIL b2b_idle got rv=%b rdy=%b cyc=%b want 0 1 0", rsp_valid, cmd_ready, wbm_cyc_o);
        end
        cyc_cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (wbm_cyc_o !== 1 || wbm_adr_o !== 32'h3003_0004 || wbm_sel_o !== 4'h1) begin
            failures++; $display("FAIL b2b_accept got cyc=%b adr=%h sel=%h want 1 30030004 1", wbm_cyc_o, wbm_adr_o, wbm_sel_o);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_dat !== 32'h0 || cyc_cnt != 2) begin
            failures++; $display("FAIL b2b_rsp got ok=%0d dat=%h cyc_cycles=%0d want 1 0 2", ok, rsp_dat, cyc_cnt);
        end
        handshake();
    endtask

`ifdef WB_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        ack_after = 0;
        wbm_dat_i = 32'hFFFF_0000;
        issue(1'b0, 32'h3003_0008, 32'h0, 4'hF);
        wait_rsp(ok);
        checks++;
        if (!ok || cyc_cnt != 8 || rsp_err !== 1 || rsp_dat !== 32'h0 || wbm_cyc_o !== 0) begin
            failures++;
            $display("FAIL timeout_rsp got ok=%0d cyc_cycles=%0d err=%b dat=%h cyc=%b want 1 8 1 0 0",
                     ok, cyc_cnt, rsp_err, rsp_dat, wbm_cyc_o);
        end
        handshake();
        ack_after = 3;
        wbm_dat_i = 32'hCAFE_0001;
        issue(1'b0, 32'h3003_0004, 32'h0, 4'hF);
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_err !== 0 || rsp_dat !== 32'hCAFE_0001 || cyc_cnt != 3) begin
            failures++;
            $display("FAIL timeout_recover got ok=%0d err=%b dat=%h cyc_cycles=%0d want 1 0 cafe0001 3",
                     ok, rsp_err, rsp_dat, cyc_cnt);
        end
        handshake();
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        ack_after = 0;
        wbm_dat_i = 32'h0000_0777;
        issue(1'b0, 32'h3003_0008, 32'h0, 4'hF);
        repeat (30) @(negedge clk);
        checks++;
        if (wbm_cyc_o !== 1 || rsp_valid !== 0) begin
            failures++; $display("FAIL wait_forever got cyc=%b rv=%b want 1 0", wbm_cyc_o, rsp_valid);
        end
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        wait_rsp(ok);
        checks++;
        if (!ok || rsp_dat !== 32'h0000_0777 || rsp_err !== 0) begin
            failures++; $display("FAIL late_ack got ok=%0d dat=%h err=%b want 1 00000777 0", ok, rsp_dat, rsp_err);
        end
        handshake();
    endtask
`endif

    task automatic test_reset_mid_bus();
        ack_after = 0;
        issue(1'b1, 32'h3003_000C, 32'h1111_2222, 4'hC);
        @(negedge clk);
        checks++;
        if (wbm_cyc_o !== 1) begin
            failures++; $display("FAIL midbus_pre got cyc=%b want 1", wbm_cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wbm_cyc_o !== 0 || wbm_stb_o !== 0 || wbm_adr_o !== 32'h0 || rsp_valid !== 0) begin
            failures++;
            $display("FAIL midbus_async_reset got cyc=%b stb=%b adr=%h rv=%b want 0 0 0 0", wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 0 || cmd_ready !== 1 || wbm_cyc_o !== 0 || rsp_dat !== 32'h0) begin
                failures++;
                $display("FAIL stray_ack[%0d] got rv=%b rdy=%b cyc=%b dat=%h want 0 1 0 0", i, rsp_valid, cmd_ready, wbm_cyc_o, rsp_dat);
            end
        end
        stray_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_dat_i = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
`ifdef WB_INITIATOR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of bus cycles waited for wbm_ack_i before abort (range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_adr in 32, cmd_dat in 32, cmd_sel in 4; this is the command request channel.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_dat out 32, rsp_err out 1; this is the response channel.
REQ-006 SHALL have ports wbm_cyc_o out 1, wbm_stb_o out 1, wbm_we_o out 1, wbm_adr_o out 32, wbm_dat_o out 32, wbm_sel_o out 4; these are the Wishbone classic master outputs.
REQ-007 SHALL have ports wbm_dat_i in 32, wbm_ack_i in 1; these are the Wishbone responder returns.

Function
REQ-008 SHALL implement three states: IDLE, BUS, RESP.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a clock edge where cmd_valid && cmd_ready.
REQ-010 On acceptance, SHALL register adr/dat/sel/we onto the wbm_* outputs, assert wbm_cyc_o and wbm_stb_o from the next cycle (1-cycle latency), and enter BUS.
REQ-011 In BUS, SHALL hold all wbm_* outputs stable until an edge with wbm_ack_i=1.
REQ-012 On ack in BUS, SHALL deassert cyc/stb at that edge, capture wbm_dat_i into rsp_dat for reads (rsp_dat=0 for writes), set rsp_err=0 and rsp_valid=1, and enter RESP.
REQ-013 In RESP, SHALL hold rsp_valid, rsp_dat and rsp_err stable until rsp_ready=1; on that edge it SHALL clear rsp_valid and enter IDLE.
REQ-014 SHALL ignore wbm_ack_i outside BUS, with no state change and no capture.
REQ-015 SHALL keep wbm_we_o=0, wbm_sel_o=0 and wbm_dat_o=0 whenever cyc is low; wbm_adr_o retains its last value.
REQ-016 SHALL issue at most one outstanding bus cycle; a back-to-back command is accepted no earlier than the cycle after the RESP handshake.

Reset
REQ-017 While rst_n=0, SHALL immediately force state=IDLE, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, wbm_sel_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, timeout counter=0; cmd_ready=1 after release.
REQ-018 On reset during BUS or RESP, SHALL abort the transfer without emitting a response.

Configuration
REQ-019 With WB_INITIATOR_TIMEOUT_EN defined, SHALL count cycles in BUS; if the count reaches TIMEOUT_CYCLES with no ack, it SHALL drop cyc/stb, set rsp_dat=0 and rsp_err=1, and enter RESP.
REQ-020 Without WB_INITIATOR_TIMEOUT_EN, SHALL wait indefinitely in BUS, tie rsp_err=0, and omit the counter logic.

Structure
REQ-021 Shared package gonso_wb_pkg SHALL hold: the state enum (IDLE/BUS/RESP), the register address constants 0x30030004, 0x30030008 and 0x3003000C, and the TIMEOUT_CYCLES default.
REQ-022 The timeout counter SHALL be the sub-module wb_timeout_counter (inputs: enable, clear; output: expired), instantiated only under WB_INITIATOR_TIMEOUT_EN.

Verification
REQ-023 Write 0x000ABCDE to 0x30030004, sel=0xF, responder acks 1 cycle after stb -> cyc/stb high exactly 2 cycles with we=1; rsp_valid=1, rsp_err=0, rsp_dat=0.
REQ-024 Read 0x30030008, responder returns 0x12345678 after 3 wait cycles -> cyc/stb high 4 cycles; rsp_dat=0x12345678, rsp_err=0.
REQ-025 TIMEOUT_EN set, TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 BUS cycles; rsp_err=1, rsp_dat=0; a following command completes normally.
REQ-026 rsp_ready held low 5 cycles after response -> rsp_valid/rsp_dat stable, cmd_ready=0, cyc=0 throughout; IDLE entered after the handshake.
REQ-027 rst_n pulsed low mid-BUS -> cyc/stb=0 asynchronously, no rsp_valid; a stray ack during IDLE -> no response generated.
